// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single RAM port between the icache and dcache of every core.
//   One requester owns the RAM at a time.  Dcache beats icache unless a
//   pending icache has been passed over STARVE_LIM times.  Ties inside a
//   class are broken round-robin from rr_ptr.  The grant is held until RAM
//   reports ACCESS, and that completion is returned to the owner as a
//   one-cycle drop of its wait line.
//
// Ports
//   CLK, RST             clock (rising edge), synchronous active-high reset
//   iREN, iaddr          icache read request / word address, per core
//   dREN, dWEN           dcache read / write request, per core
//   daddr, dstore        dcache word address / write data, per core
//   iwait, dwait         1 = requester must keep waiting
//   iload, dload         ramload broadcast to every cache
//   ramREN, ramWEN       RAM read / write enable
//   ramaddr, ramstore    RAM address / write data
//   ramload              RAM read data
//   ramstate             0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
module mem_arbiter #(
    parameter int NCPU       = 2,
    parameter int STARVE_LIM = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NCPU-1:0]           iREN,
    input  logic [NCPU-1:0][31:0]     iaddr,
    input  logic [NCPU-1:0]           dREN,
    input  logic [NCPU-1:0]           dWEN,
    input  logic [NCPU-1:0][31:0]     daddr,
    input  logic [NCPU-1:0][31:0]     dstore,
    output logic [NCPU-1:0]           iwait,
    output logic [NCPU-1:0]           dwait,
    output logic [NCPU-1:0][31:0]     iload,
    output logic [NCPU-1:0][31:0]     dload,
    output logic                      ramREN,
    output logic                      ramWEN,
    output logic [31:0]               ramaddr,
    output logic [31:0]               ramstore,
    input  logic [31:0]               ramload,
    input  logic [1:0]                ramstate
);

    localparam int CPU_W = (NCPU > 1) ? $clog2(NCPU) : 1;
    localparam int SC_W  = $clog2(STARVE_LIM + 1);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {IDLE, SERVE} state_t;

    typedef struct packed {
        logic             is_d;
        logic [CPU_W-1:0] cpu;
    } owner_t;

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [CPU_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SC_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic [NCPU-1:0]  d_req;
    logic             own_req;
    logic             starved;

    // First requester at or after ptr, wrapping mod NCPU.  Scanning from the
    // far end down lets the nearest match overwrite the rest.
    function automatic logic [CPU_W-1:0] rr_pick(input logic [NCPU-1:0] req,
                                                 input logic [CPU_W-1:0] ptr);
        int idx;
        rr_pick = ptr;
        for (int k = NCPU - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NCPU;
            if (req[idx]) rr_pick = CPU_W'(idx);
        end
    endfunction

    assign iload = {NCPU{ramload}};
    assign dload = {NCPU{ramload}};

    assign d_req   = dREN | dWEN;
    assign own_req = owner_q.is_d ? d_req[owner_q.cpu] : iREN[owner_q.cpu];
    assign starved = (|iREN) && (starve_cnt_q >= SC_W'(STARVE_LIM));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        iwait        = '1;
        dwait        = '1;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        // Counts every cycle a pending icache is not the one being served,
        // including IDLE bubbles; saturates at the limit.
        if ((|iREN) && !(state_q == SERVE && !owner_q.is_d)
            && starve_cnt_q < SC_W'(STARVE_LIM))
            starve_cnt_d = starve_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (starved) begin
                    owner_d = '{is_d: 1'b0, cpu: rr_pick(iREN, rr_ptr_q)};
                    state_d = SERVE;
                end else if (|d_req) begin
                    owner_d = '{is_d: 1'b1, cpu: rr_pick(d_req, rr_ptr_q)};
                    state_d = SERVE;
                end else if (|iREN) begin
                    owner_d = '{is_d: 1'b0, cpu: rr_pick(iREN, rr_ptr_q)};
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (!own_req) begin
                    // Owner gave up before completion: release silently.
                    state_d = IDLE;
                end else begin
                    if (owner_q.is_d) begin
                        ramaddr  = daddr[owner_q.cpu];
                        ramstore = dstore[owner_q.cpu];
                        ramWEN   = dWEN[owner_q.cpu];
                        ramREN   = dREN[owner_q.cpu] & ~dWEN[owner_q.cpu];
                    end else begin
                        ramaddr  = iaddr[owner_q.cpu];
                        ramREN   = 1'b1;
                    end
                    if (ramstate == RAM_ACCESS) begin
                        if (owner_q.is_d) dwait[owner_q.cpu] = 1'b0;
                        else begin
                            iwait[owner_q.cpu] = 1'b0;
                            starve_cnt_d       = '0;
                        end
                        rr_ptr_d = (int'(owner_q.cpu) == NCPU - 1) ? '0
                                                                   : owner_q.cpu + 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // While reset is held nothing may complete or reach the RAM.
        if (RST) begin
            iwait    = '1;
            dwait    = '1;
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = '0;
            ramstore = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (NCPU=2, STARVE_LIM=8).  Inputs change on
// the falling edge; outputs are sampled 1 time unit later.
module tb_mem_arbiter;

    localparam int NCPU = 2;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

    logic                  CLK;
    logic                  RST;
    logic [NCPU-1:0]       iREN, dREN, dWEN;
    logic [NCPU-1:0][31:0] iaddr, daddr, dstore;
    logic [NCPU-1:0]       iwait, dwait;
    logic [NCPU-1:0][31:0] iload, dload;
    logic                  ramREN, ramWEN;
    logic [31:0]           ramaddr, ramstore, ramload;
    logic [1:0]            ramstate;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.NCPU(NCPU), .STARVE_LIM(8)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    logic [1:0]  rr_dw [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [31:0] rr_ad [4] = '{32'h100, 32'h104, 32'h100, 32'h104};

    initial begin
        RST = 1'b1; iREN = '1; dREN = '1; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = 32'h1234_5678; ramstate = FREE;

        // reset with every request asserted
        step(); #1;
        chk("rst_iwait", 32'(iwait), 32'h3);
        chk("rst_dwait", 32'(dwait), 32'h3);
        chk("rst_ren", 32'(ramREN), 0);
        chk("rst_wen", 32'(ramWEN), 0);
        chk("rst_addr", ramaddr, 0);
        chk("iload_bcast", iload[1], 32'h1234_5678);

        // single icache, two BUSY then ACCESS
        step(); RST = 1'b0; iREN = 2'b01; dREN = '0; iaddr[0] = 32'h40; ramstate = BUSY; #1;
        chk("i_idle_ren", 32'(ramREN), 0);
        chk("i_idle_iwait", 32'(iwait), 32'h3);
        for (int c = 0; c < 2; c++) begin
            step(); #1;
            chk("i_busy_ren", 32'(ramREN), 1);
            chk("i_busy_addr", ramaddr, 32'h40);
            chk("i_busy_iwait", 32'(iwait), 32'h3);
        end
        step(); ramstate = ACCESS; #1;
        chk("i_acc_ren", 32'(ramREN), 1);
        chk("i_acc_addr", ramaddr, 32'h40);
        chk("i_acc_iwait", 32'(iwait), 32'h2);
        step(); iREN = '0; ramstate = FREE; #1;
        chk("i_after_iwait", 32'(iwait), 32'h3);
        chk("i_after_ren", 32'(ramREN), 0);

        // dcache write beats simultaneous icache read
        step(); iREN = 2'b01; iaddr[0] = 32'h44; dWEN = 2'b10;
        daddr[1] = 32'h80; dstore[1] = 32'hBEEF; ramstate = ACCESS; #1;
        chk("dvi_idle_dwait", 32'(dwait), 32'h3);
        chk("dvi_idle_iwait", 32'(iwait), 32'h3);
        step(); #1;
        chk("dvi_d_wen", 32'(ramWEN), 1);
        chk("dvi_d_ren", 32'(ramREN), 0);
        chk("dvi_d_addr", ramaddr, 32'h80);
        chk("dvi_d_store", ramstore, 32'hBEEF);
        chk("dvi_d_dwait", 32'(dwait), 32'h1);
        chk("dvi_d_iwait", 32'(iwait), 32'h3);
        step(); dWEN = '0; #1;
        chk("dvi_bubble", 32'(dwait & iwait), 32'h3);
        step(); #1;
        chk("dvi_i_ren", 32'(ramREN), 1);
        chk("dvi_i_wen", 32'(ramWEN), 0);
        chk("dvi_i_addr", ramaddr, 32'h44);
        chk("dvi_i_iwait", 32'(iwait), 32'h2);
        step(); iREN = '0; #1;

        // round-robin between two continuous dcache reads
        step(); RST = 1'b1;
        step(); RST = 1'b0; dREN = 2'b11; daddr[0] = 32'h100; daddr[1] = 32'h104; #1;
        chk("rr_idle", 32'(dwait), 32'h3);
        for (int g = 0; g < 4; g++) begin
            step(); #1;
            chk("rr_dwait", 32'(dwait), 32'(rr_dw[g]));
            chk("rr_addr", ramaddr, rr_ad[g]);
            step(); if (g == 3) dREN = '0; #1;
            chk("rr_bubble", 32'(dwait), 32'h3);
        end

        // starvation: icache1 forced in after dcache0 wins repeatedly
        step(); RST = 1'b1;
        step(); RST = 1'b0; dREN = 2'b01; iREN = 2'b10;
        daddr[0] = 32'h200; iaddr[1] = 32'h300; ramstate = ACCESS; #1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin step(); #1; end
            chk("stv_iwait", 32'(iwait), (c == 9) ? 32'h1 : 32'h3);
            chk("stv_dwait", 32'(dwait), (c % 2 == 1 && c < 9) ? 32'h2 : 32'h3);
        end
        chk("stv_addr", ramaddr, 32'h300);
        step(); iREN = '0; dREN = '0; #1;
        chk("stv_after", 32'(iwait), 32'h3);

        // owner drops request mid-BUSY
        step(); dREN = 2'b01; daddr[0] = 32'h200; ramstate = BUSY; #1;
        chk("ab_idle", 32'(dwait), 32'h3);
        step(); #1;
        chk("ab_serve_ren", 32'(ramREN), 1);
        chk("ab_serve_dwait", 32'(dwait), 32'h3);
        step(); dREN = '0; #1;
        chk("ab_drop_ren", 32'(ramREN), 0);
        chk("ab_drop_dwait", 32'(dwait), 32'h3);
        step(); ramstate = ACCESS; dREN = 2'b10; daddr[1] = 32'h204; #1;
        chk("ab_back_idle", 32'(dwait), 32'h3);
        step(); #1;
        chk("ab_next_dwait", 32'(dwait), 32'h1);
        chk("ab_next_addr", ramaddr, 32'h204);
        step(); dREN = '0; #1;

        // reset in the middle of a transaction
        step(); dREN = 2'b01; ramstate = BUSY; #1;
        step(); #1;
        chk("rs_serve_ren", 32'(ramREN), 1);
        step(); RST = 1'b1; ramstate = ACCESS; #1;
        chk("rs_hold_dwait", 32'(dwait), 32'h3);
        chk("rs_hold_ren", 32'(ramREN), 0);
        step(); RST = 1'b0; #1;
        chk("rs_idle_ren", 32'(ramREN), 0);
        chk("rs_idle_dwait", 32'(dwait), 32'h3);
        step(); #1;
        chk("rs_regrant", 32'(dwait), 32'h2);
        step(); dREN = '0; #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
